// File: rtl/ft245_fifo_if.sv
// FT2232/FT245 async-FIFO bridge: counted read/write strobe phases on the chip pins,
// with TX and RX byte FIFOs exposed to the fabric as valid/ready streams.
module ft245_fifo_if #(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_PULSE    = 4,
  parameter int unsigned WR_SETUP    = 2,
  parameter int unsigned WR_PULSE    = 3,
  parameter int unsigned RECOVER     = 6
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        nrxf_i,
  input  logic                        ntxe_i,
  output logic                        nrd_o,
  output logic                        wr_o,
  inout  wire  [7:0]                  d_io,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic [$clog2(RX_DEPTH):0]   rx_level_o
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  // Recovery must outlast the flag synchronisers so a stale flag never starts a transfer.
  localparam int unsigned RecEff = (RECOVER > SYNC_STAGES + 1) ? RECOVER : SYNC_STAGES + 1;
  localparam int unsigned CntW = 8;

  typedef enum logic [2:0] {StIdle, StRd, StWs, StWp, StRec} state_e;

  // Flag synchronisers
  logic [SYNC_STAGES-1:0] nrxf_sync_q, ntxe_sync_q;
  logic nrxf_s, ntxe_s;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      nrxf_sync_q <= '1;
      ntxe_sync_q <= '1;
    end else begin
      nrxf_sync_q <= {nrxf_sync_q[SYNC_STAGES-2:0], nrxf_i};
      ntxe_sync_q <= {ntxe_sync_q[SYNC_STAGES-2:0], ntxe_i};
    end
  end

  assign nrxf_s = nrxf_sync_q[SYNC_STAGES-1];
  assign ntxe_s = ntxe_sync_q[SYNC_STAGES-1];

  // TX FIFO (fabric -> host)
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [TxAw:0] tx_wptr_q, tx_rptr_q, tx_level;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0] tx_head;

  assign tx_level   = tx_wptr_q - tx_rptr_q;
  assign tx_full    = (tx_level == (TxAw+1)'(TX_DEPTH));
  assign tx_empty   = (tx_level == '0);
  assign tx_push    = tx_valid_i & ~tx_full;
  assign tx_head    = tx_mem[tx_rptr_q[TxAw-1:0]];
  assign tx_ready_o = ~tx_full;
  assign tx_level_o = tx_level;

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wptr_q[TxAw-1:0]] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // RX FIFO (host -> fabric), first-word fall-through
  logic [7:0]  rx_mem [RX_DEPTH];
  logic [RxAw:0] rx_wptr_q, rx_rptr_q, rx_level;
  logic rx_full, rx_empty, rx_push, rx_pop;

  assign rx_level   = rx_wptr_q - rx_rptr_q;
  assign rx_full    = (rx_level == (RxAw+1)'(RX_DEPTH));
  assign rx_empty   = (rx_level == '0);
  assign rx_pop     = rx_ready_i & ~rx_empty;
  assign rx_data_o  = rx_mem[rx_rptr_q[RxAw-1:0]];
  assign rx_valid_o = ~rx_empty;
  assign rx_level_o = rx_level;

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wptr_q[RxAw-1:0]] <= d_io;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // Bus FSM
  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic last_rd_q, last_rd_d;
  logic [7:0] out_q, out_d;
  logic nrd_q, wr_q, oe_q;
  logic rd_ok, wr_ok;

  assign rd_ok = ~nrxf_s & ~rx_full;
  assign wr_ok = ~ntxe_s & ~tx_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    out_d     = out_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // When both sides are ready, serve the one not served last time.
        if (rd_ok && (!wr_ok || !last_rd_q)) begin
          state_d   = StRd;
          cnt_d     = CntW'(RD_PULSE - 1);
          last_rd_d = 1'b1;
        end else if (wr_ok) begin
          state_d   = StWs;
          cnt_d     = CntW'(WR_SETUP - 1);
          last_rd_d = 1'b0;
          out_d     = tx_head;
          tx_pop    = 1'b1;
        end
      end
      StRd: begin
        if (cnt_q == '0) begin
          rx_push = 1'b1;
          state_d = StRec;
          cnt_d   = CntW'(RecEff - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWs: begin
        if (cnt_q == '0) begin
          state_d = StWp;
          cnt_d   = CntW'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWp: begin
        if (cnt_q == '0) begin
          state_d = StRec;
          cnt_d   = CntW'(RecEff - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRec: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
      out_q     <= '0;
      nrd_q     <= 1'b1;
      wr_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      out_q     <= out_d;
      // Strobes follow the next state so they line up exactly with the state register.
      nrd_q     <= (state_d != StRd);
      wr_q      <= (state_d == StWp);
      oe_q      <= (state_d == StWs) || (state_d == StWp) ||
                   ((state_q == StWp) && (state_d == StRec));
    end
  end

  assign nrd_o = nrd_q;
  assign wr_o  = wr_q;
  assign d_io  = oe_q ? out_q : 8'bz;

endmodule

// File: tb/tb_ft245_fifo_if.sv
// Bench for ft245_fifo_if: FT chip model on the pins, scoreboard queues checked by a
// negedge monitor, plus directed timing measurements.
module tb_ft245_fifo_if;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       nrxf = 1'b1;
  logic       ntxe = 1'b1;
  wire  [7:0] d_bus;
  logic       nrd, wr;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] tx_level, rx_level;

  always #5 clk = ~clk;

  ft245_fifo_if dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .nrxf_i     (nrxf),
    .ntxe_i     (ntxe),
    .nrd_o      (nrd),
    .wr_o       (wr),
    .d_io       (d_bus),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .tx_level_o (tx_level),
    .rx_level_o (rx_level)
  );

  // Released bus reads as 8'hFF through the pull-up.
  pullup pu_d (d_bus);

  // FT chip model: drives the head byte while nrd is low, drops it when nrd rises.
  logic [7:0] host_q[$];
  bit         host_en = 1'b0;
  logic [7:0] host_drv = 8'h00;
  bit         rd_active = 1'b0;

  assign d_bus = (!nrd) ? host_drv : 8'bz;

  always @(negedge clk) begin
    nrxf     = !(host_en && host_q.size() != 0);
    host_drv = (host_q.size() != 0) ? host_q[0] : 8'h00;
  end

  always @(negedge nrd) rd_active = 1'b1;
  always @(posedge nrd) begin
    if (rd_active) begin
      rd_active = 1'b0;
      if (host_q.size() != 0) void'(host_q.pop_front());
    end
  end

  // Scoreboard
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  bit         exp_op_q[$];
  bit         op_check_en = 1'b0;
  int         rd_pulses = 0;
  int         wr_done = 0;
  logic       prev_nrd = 1'b1;
  logic       prev_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic op_seen(input bit op);
    if (exp_op_q.size() == 0) check("op_unexpected", {31'd0, op}, 32'd2);
    else check("op_order", {31'd0, op}, {31'd0, exp_op_q.pop_front()});
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'h100);
        else check("rx_byte", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
      end
      if (prev_nrd && !nrd) begin
        rd_pulses++;
        if (op_check_en) op_seen(1'b0);
      end
      if (!prev_wr && wr && op_check_en) op_seen(1'b1);
      if (prev_wr && !wr) begin
        wr_done++;
        if (exp_tx_q.size() == 0) check("tx_unexpected", {24'd0, d_bus}, 32'h100);
        else check("tx_byte", {24'd0, d_bus}, {24'd0, exp_tx_q.pop_front()});
      end
    end
    prev_nrd = nrd;
    prev_wr  = wr;
  end

  task automatic push_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, wd;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_nrd", nrd, 1);
    check("rst_wr", wr, 0);
    check("rst_d_released", d_bus, 8'hFF);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Host read: latency and pulse width
    host_q.push_back(8'hA5);
    host_en = 1'b1;
    @(negedge clk);
    n = 0;
    while (nrd !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("rd_latency", n, 3);
    n = 0;
    while (nrd === 1'b0 && n < 20) begin n++; @(negedge clk); end
    check("rd_pulse_len", n, 4);
    repeat (2) @(negedge clk);
    check("rd_rx_valid", rx_valid, 1);
    check("rd_rx_data", rx_data, 8'hA5);
    check("rd_rx_level", rx_level, 1);

    // Back-to-back reads: nrd high gap = effective recovery + idle cycle
    @(posedge clk); #1;
    exp_rx_q.push_back(8'hA5);
    exp_rx_q.push_back(8'hB1);
    exp_rx_q.push_back(8'hB2);
    host_q.push_back(8'hB1);
    host_q.push_back(8'hB2);
    rx_ready = 1'b1;
    n = 0;
    while (nrd !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    check("rd2_start", n < 40, 1);
    n = 0;
    while (nrd === 1'b0 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (nrd !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    check("rd_gap", n, 7);
    n = 0;
    while (exp_rx_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("rx_drain", exp_rx_q.size(), 0);
    check("rx_level_empty", rx_level, 0);
    host_en = 1'b0;

    // Write phase timing
    @(posedge clk); #1;
    ntxe = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("tx_ready_before_push", tx_ready, 1);
    exp_tx_q.push_back(8'h3C);
    push_tx(8'h3C);
    @(negedge clk);
    n = 0;
    while (!(wr === 1'b0 && d_bus === 8'h3C) && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (wr === 1'b0 && d_bus === 8'h3C && n < 20) begin n++; @(negedge clk); end
    check("ws_cycles", n, 2);
    n = 0;
    while (wr === 1'b1 && d_bus === 8'h3C && n < 20) begin n++; @(negedge clk); end
    check("wp_cycles", n, 3);
    n = 0;
    while (wr === 1'b0 && d_bus === 8'h3C && n < 20) begin n++; @(negedge clk); end
    check("hold_cycles", n, 1);
    check("wr_d_released", d_bus, 8'hFF);
    check("wr_tx_level", tx_level, 0);

    // ntxe rises during WS: current byte completes, next waits
    repeat (12) @(posedge clk); #1;
    exp_tx_q.push_back(8'h5A);
    push_tx(8'h5A);
    push_tx(8'hC3);
    @(negedge clk);
    n = 0;
    while (!(wr === 1'b0 && d_bus === 8'h5A) && n < 20) begin @(negedge clk); n++; end
    check("ws_seen", n < 20, 1);
    @(posedge clk); #1 ntxe = 1'b1;
    wd = wr_done;
    repeat (40) @(posedge clk); #1;
    check("wr_after_ntxe_high", wr_done - wd, 1);
    check("tx_level_held", tx_level, 1);
    exp_tx_q.push_back(8'hC3);
    ntxe = 1'b0;
    n = 0;
    while (exp_tx_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    check("tx_drain_c3", exp_tx_q.size(), 0);

    // Reset mid-WP: write aborted, byte lost
    repeat (12) @(posedge clk); #1;
    push_tx(8'h77);
    n = 0;
    while (wr !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 reset_n = 1'b0;
    ntxe = 1'b1;
    @(negedge clk);
    check("midwp_wr", wr, 0);
    check("midwp_nrd", nrd, 1);
    check("midwp_d_released", d_bus, 8'hFF);
    check("midwp_tx_level", tx_level, 0);
    check("midwp_tx_ready", tx_ready, 1);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Arbitration: read first after reset, then alternate
    for (int i = 0; i < 4; i++) begin
      exp_tx_q.push_back(8'h10 + 8'(i));
      push_tx(8'h10 + 8'(i));
      host_q.push_back(8'h80 + 8'(i));
      exp_rx_q.push_back(8'h80 + 8'(i));
      exp_op_q.push_back(1'b0);
      exp_op_q.push_back(1'b1);
    end
    op_check_en = 1'b1;
    rx_ready = 1'b1;
    host_en = 1'b1;
    ntxe = 1'b0;
    n = 0;
    while (exp_op_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("arb_ops_done", exp_op_q.size(), 0);
    repeat (30) @(posedge clk); #1;
    op_check_en = 1'b0;
    check("arb_tx_done", exp_tx_q.size(), 0);
    check("arb_rx_done", exp_rx_q.size(), 0);

    // RX full backpressure
    rx_ready = 1'b0;
    ntxe = 1'b1;
    for (int i = 0; i < 18; i++) begin
      host_q.push_back(8'h20 + 8'(i));
      exp_rx_q.push_back(8'h20 + 8'(i));
    end
    n = 0;
    while (rx_level != 5'd16 && n < 400) begin @(negedge clk); n++; end
    check("rx_fill", rx_level, 16);
    p0 = rd_pulses;
    repeat (40) @(posedge clk); #1;
    check("rx_full_no_read", rd_pulses - p0, 0);
    rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("one_read_after_pop", rd_pulses - p0, 1);
    check("rx_full_again", rx_level, 16);
    rx_ready = 1'b1;
    n = 0;
    while (exp_rx_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("rx_full_drain", exp_rx_q.size(), 0);
    host_en = 1'b0;
    rx_ready = 1'b0;

    // TX full: 17th push refused
    for (int i = 0; i < 16; i++) begin
      exp_tx_q.push_back(8'h40 + 8'(i));
      push_tx(8'h40 + 8'(i));
    end
    check("tx_full_level", tx_level, 16);
    check("tx_full_ready", tx_ready, 0);
    push_tx(8'hEE);
    check("tx_17th_refused", tx_level, 16);
    ntxe = 1'b0;
    n = 0;
    while (exp_tx_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    check("tx_full_drain", exp_tx_q.size(), 0);
    repeat (20) @(posedge clk); #1;
    check("tx_final_level", tx_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
